tetris_cmd_scheduler: RTL
=========================

TETRIS_CMD_SCHEDULER -- requirements
Module: tetris_cmd_scheduler

Interface
REQ-001 SHALL have parameter GRAVITY_DIV, default 5000000: clock cycles per gravity tick (minimum 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: key-command FIFO entries (power of two).
REQ-003 SHALL have port clock, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ps2_key_pressed, input, 1: one-cycle strobe marking a new scan byte.
REQ-006 SHALL have port ps2_key_data, input, 8: scan byte, valid when ps2_key_pressed=1.
REQ-007 SHALL have port game_run, input, 1: 1 = game active; 0 = scheduler idle and flushed.
REQ-008 SHALL have port cmd_ready, input, 1: game datapath accepts the current command.
REQ-009 SHALL have port cmd_valid, output, 1: command presented.
REQ-010 SHALL have port cmd_code, output, 2: 00 LEFT, 01 RIGHT, 10 DOWN, 11 ROTATE.
REQ-011 SHALL have port cmd_src, output, 1: 0 = keyboard, 1 = gravity.
REQ-012 SHALL have port fifo_count, output, log2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-013 SHALL have port drop_count, output, 8: saturating count of dropped key commands.

Function
REQ-014 SHALL decode scan bytes with FSM states MAKE and BREAK; all transitions occur only on edges where ps2_key_pressed=1.
REQ-015 In MAKE: byte F0 -> BREAK; byte E0 -> stay in MAKE, no command; 6B/74/72/75 -> push LEFT/RIGHT/DOWN/ROTATE respectively; any other byte -> ignored.
REQ-016 In BREAK: any byte -> MAKE, no command (the released key's code is discarded).
REQ-017 Push SHALL occur on the same edge that samples the make byte; decoding SHALL proceed when game_run=0 but no push occurs then.
REQ-018 FIFO full and push without pop -> command dropped, drop_count += 1, saturating at 255.
REQ-019 FIFO full with simultaneous push and pop -> both occur, no drop, count unchanged.
REQ-020 Gravity counter SHALL run 0..GRAVITY_DIV-1 while game_run=1; on the edge where it wraps to 0, gravity_pending SHALL be set.
REQ-021 A wrap while gravity_pending is already set SHALL be absorbed (not queued twice).
REQ-022 Output register is empty when cmd_valid=0, or on an edge where cmd_valid=1 and cmd_ready=1; on such an edge it SHALL load the next command if one is available, so back-to-back issue is possible.
REQ-023 When one source is pending, it wins. When both gravity_pending and FIFO non-empty, grant SHALL alternate using last_grant (reset = keyboard, so gravity wins first).
REQ-024 Gravity grant -> cmd_code=10, cmd_src=1, clear gravity_pending. Keyboard grant -> pop FIFO head, cmd_src=0.
REQ-025 Latency: a push or a pending-set at edge N with an empty output register -> cmd_valid=1 after edge N+1.
REQ-026 While cmd_valid=1 and cmd_ready=0, cmd_valid, cmd_code and cmd_src SHALL hold stable.
REQ-027 game_run=0 SHALL synchronously flush the FIFO, zero the gravity counter and clear gravity_pending.
REQ-028 A command already presented when game_run falls SHALL remain valid until accepted; no new loads occur while game_run=0.
REQ-029 drop_count SHALL be unaffected by game_run.

Reset
REQ-030 resetn=0 SHALL immediately set: cmd_valid=0, cmd_code=00, cmd_src=0, fifo_count=0, drop_count=0, gravity counter=0, gravity_pending=0, decoder=MAKE, last_grant=keyboard.
REQ-031 A reset asserted mid-handshake SHALL abort the command; the first command after reset deassertion follows REQ-025.

Verification (GRAVITY_DIV=8, FIFO_DEPTH=4)
REQ-032 Key order: game_run=1, cmd_ready=1, bytes 6B then 74 -> LEFT then RIGHT issued with cmd_src=0, each cmd_valid one cycle after its byte.
REQ-033 Break code: bytes F0, 6B -> no command issued; next byte 75 -> ROTATE issued.
REQ-034 Overflow: cmd_ready=0, six LEFT makes -> one held in the output register, fifo_count=4, drop_count=1; raise cmd_ready -> exactly five LEFTs issued.
REQ-035 Arbitration: cmd_ready=0 until gravity pending and FIFO holds RIGHT, then cmd_ready=1 -> gravity DOWN (src=1), RIGHT, gravity DOWN alternate; pending never double-counted.
REQ-036 Stall hold: cmd_valid=1, cmd_ready=0 for 10 cycles while bytes arrive -> cmd_code and cmd_src constant for all 10 cycles.
REQ-037 Flush/reset: FIFO at 3, game_run=0 -> fifo_count=0 next edge, no gravity issue for 20 cycles; resetn pulse mid-stall -> all outputs zero asynchronously.

Source files
------------

// File: rtl/tetris_cmd_scheduler.sv
// Tetris command scheduler: PS/2 make-code decoder, key FIFO,
// gravity tick generator and a fair two-source command arbiter.
module tetris_cmd_scheduler #(
   parameter int GRAVITY_DIV = 5000000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          clock,
   input  logic                          resetn,
   input  logic                          ps2_key_pressed,
   input  logic [7:0]                    ps2_key_data,
   input  logic                          game_run,
   input  logic                          cmd_ready,
   output logic                          cmd_valid,
   output logic [1:0]                    cmd_code,
   output logic                          cmd_src,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [7:0]                    drop_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int GW = $clog2(GRAVITY_DIV);

   typedef enum logic {MAKE, BREAK} dec_state_t;

   dec_state_t    dec_state;
   logic [1:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [GW-1:0] grav_cnt;
   logic          grav_pending;
   logic          last_grant;
   logic          key_hit;
   logic [1:0]    key_code;
   logic          push_req;
   logic          fifo_empty;
   logic          fifo_full;
   logic          load_en;
   logic          grant_grav;
   logic          grant_kbd;
   logic          push;
   logic          drop;
   logic          grav_wrap;

   always_comb begin
      key_hit  = 1'b1;
      key_code = 2'b00;
      case (ps2_key_data)
         8'h6B:   key_code = 2'b00;
         8'h74:   key_code = 2'b01;
         8'h72:   key_code = 2'b10;
         8'h75:   key_code = 2'b11;
         default: key_hit  = 1'b0;
      endcase
   end

   // last_grant: 0 = keyboard, 1 = gravity
   assign push_req   = ps2_key_pressed && (dec_state == MAKE)
                       && game_run && key_hit;
   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
   assign load_en    = game_run && (!cmd_valid || cmd_ready);
   assign grant_grav = load_en && grav_pending
                       && (fifo_empty || !last_grant);
   assign grant_kbd  = load_en && !fifo_empty && !grant_grav;
   assign push       = push_req && (!fifo_full || grant_kbd);
   assign drop       = push_req && fifo_full && !grant_kbd;
   assign grav_wrap  = game_run && (grav_cnt == GW'(GRAVITY_DIV - 1));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         dec_state <= MAKE;
      end else if (ps2_key_pressed) begin
         if (dec_state == BREAK)
            dec_state <= MAKE;
         else if (ps2_key_data == 8'hF0)
            dec_state <= BREAK;
      end
   end

   always_ff @(posedge clock) begin
      if (push)
         fifo_mem[wr_ptr] <= key_code;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (!game_run) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (grant_kbd)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !grant_kbd)
            fifo_count <= fifo_count + 1'b1;
         else if (!push && grant_kbd)
            fifo_count <= fifo_count - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         drop_count <= '0;
      else if (drop && (drop_count != 8'hFF))
         drop_count <= drop_count + 1'b1;
   end

   // A wrap on the same edge as a gravity grant re-arms the tick.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         grav_cnt     <= '0;
         grav_pending <= 1'b0;
      end else if (!game_run) begin
         grav_cnt     <= '0;
         grav_pending <= 1'b0;
      end else begin
         grav_cnt <= grav_wrap ? '0 : grav_cnt + 1'b1;
         if (grav_wrap)
            grav_pending <= 1'b1;
         else if (grant_grav)
            grav_pending <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cmd_valid  <= 1'b0;
         cmd_code   <= 2'b00;
         cmd_src    <= 1'b0;
         last_grant <= 1'b0;
      end else if (load_en) begin
         cmd_valid <= grant_grav || grant_kbd;
         if (grant_grav) begin
            cmd_code   <= 2'b10;
            cmd_src    <= 1'b1;
            last_grant <= 1'b1;
         end else if (grant_kbd) begin
            cmd_code   <= fifo_mem[rd_ptr];
            cmd_src    <= 1'b0;
            last_grant <= 1'b0;
         end
      end else if (cmd_valid && cmd_ready) begin
         cmd_valid <= 1'b0;
      end
   end

endmodule
